uart_line_console: RTL

- Parametrised line-oriented console between the usb_uart byte pipelines and the CAPP control logic.
- Assembles host characters into a line buffer stored in natural order (first char in bits [7:0]). Supports backspace editing, optional echo and overflow flagging.
- Hands each completed line downstream over a valid/ready handshake, then accepts a variable-length response string and transmits it to the host with CR LF appended.

---
 rtl/console_pkg.sv | 24 ++
 rtl/uart_line_console_if.sv | 34 +++
 rtl/console_tx_seq.sv | 103 ++++++++++
 rtl/uart_line_console.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared types and constants for the UART line console: FSM states, ASCII
// control codes and a width helper.
package console_pkg;

    typedef enum logic [2:0] {
        S_RX   = 3'd0,
        S_ECHO = 3'd1,
        S_LINE = 3'd2,
        S_RESP = 3'd3,
        S_TX   = 3'd4
    } state_e;

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] DEL = 8'h7F;
    localparam logic [7:0] SP  = 8'h20;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_line_console_if.sv
// Byte pipelines, line hand-off and response hand-off of the line console.
interface uart_line_console_if #(
    parameter int LINE_LEN = 32,
    parameter int RESP_LEN = 32,
    parameter int CW       = $clog2(LINE_LEN + 1),
    parameter int RW       = $clog2(RESP_LEN + 1)
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [8*LINE_LEN-1:0] line_data;
    logic [CW-1:0]         line_len;
    logic                  line_ovf;
    logic                  line_valid;
    logic                  line_ready;
    logic [8*RESP_LEN-1:0] resp_data;
    logic [RW-1:0]         resp_len;
    logic                  resp_valid;
    logic                  resp_ready;

    modport slave (
        input  rx_data, rx_valid, tx_ready, line_ready, resp_data, resp_len, resp_valid,
        output rx_ready, tx_data, tx_valid, line_data, line_len, line_ovf, line_valid, resp_ready
    );

    modport master (
        output rx_data, rx_valid, tx_ready, line_ready, resp_data, resp_len, resp_valid,
        input  rx_ready, tx_data, tx_valid, line_data, line_len, line_ovf, line_valid, resp_ready
    );

endinterface

// File: rtl/console_tx_seq.sv
// Byte serializer: streams len_i bytes of data_i, optionally followed by CR LF,
// at up to one byte per cycle; done_o pulses with the final handshake.
module console_tx_seq
    import console_pkg::*;
#(
    parameter int N  = 32,
    parameter int LW = clog2_min1(N + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [8*N-1:0] data_i,
    input  logic [LW-1:0]  len_i,
    input  logic           crlf_i,
    output logic           tx_valid_o,
    output logic [7:0]     tx_data_o,
    input  logic           tx_ready_i,
    output logic           done_o
);
    localparam int IW = clog2_min1(N + 3);

    logic          active_q, active_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] len_q, len_d;
    logic [IW-1:0] total_q, total_d;
    logic          empty_q, empty_d;
    logic          last_fire;

    // Indices past the payload map onto the CR LF trailer.
    function automatic logic [7:0] byte_at(input logic [8*N-1:0] d,
                                           input logic [IW-1:0] i,
                                           input logic [IW-1:0] n);
        logic [7:0] b;
        b = LF;
        if (i < n) begin
            b = 8'h00;
            for (int k = 0; k < N; k++) begin
                if (i == IW'(k)) b = d[8*k +: 8];
            end
        end else if (i == n) begin
            b = CR;
        end
        return b;
    endfunction

    assign last_fire  = active_q && tx_valid_q && tx_ready_i && (idx_q == total_q);
    assign done_o     = last_fire || empty_q;
    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;

    always_comb begin
        active_d   = active_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        idx_d      = idx_q;
        len_d      = len_q;
        total_d    = total_q;
        empty_d    = 1'b0;
        if (start_i && !active_q) begin
            len_d   = IW'(len_i);
            total_d = IW'(len_i) + (crlf_i ? IW'(2) : IW'(0));
            if (total_d == '0) begin
                empty_d = 1'b1;
            end else begin
                active_d   = 1'b1;
                tx_valid_d = 1'b1;
                tx_data_d  = byte_at(data_i, '0, len_d);
                idx_d      = IW'(1);
            end
        end else if (active_q && tx_valid_q && tx_ready_i) begin
            if (idx_q == total_q) begin
                active_d   = 1'b0;
                tx_valid_d = 1'b0;
            end else begin
                tx_data_d = byte_at(data_i, idx_q, len_q);
                idx_d     = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            total_q    <= '0;
            empty_q    <= 1'b0;
        end else begin
            active_q   <= active_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            total_q    <= total_d;
            empty_q    <= empty_d;
        end
    end

endmodule

// File: rtl/uart_line_console.sv
// Line-oriented console: edits host characters into a line, hands the line
// downstream, then transmits the returned response followed by CR LF.
module uart_line_console
    import console_pkg::*;
#(
    parameter int LINE_LEN = 32,
    parameter int RESP_LEN = 32,
    parameter bit ECHO_EN  = 1'b1,
    parameter int CW       = $clog2(LINE_LEN + 1),
    parameter int RW       = $clog2(RESP_LEN + 1)
) (
    input  logic               clk_48mhz,
    input  logic               reset_n,
    uart_line_console_if.slave bus,
    output logic               busy
);
    localparam int SN  = (RESP_LEN > 3) ? RESP_LEN : 3;
    localparam int SLW = clog2_min1(SN + 1);
    localparam logic [CW-1:0] LINE_MAX = CW'(LINE_LEN);
    localparam logic [RW-1:0] RMAX     = RW'(RESP_LEN);

    logic [1:0] rst_sync_q;
    logic       rst_n;

    state_e                state_q, state_d;
    logic [7:0]            line_q [LINE_LEN];
    logic [7:0]            line_d [LINE_LEN];
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            echo_q [3];
    logic [7:0]            echo_d [3];
    logic [1:0]            echo_len_q, echo_len_d;
    logic [8*RESP_LEN-1:0] resp_q, resp_d;
    logic [RW-1:0]         rlen_q, rlen_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  line_valid_q, line_valid_d;
    logic                  resp_ready_q, resp_ready_d;
    logic                  start_q, start_d;

    logic                  rx_fire, line_fire, resp_fire;
    logic                  is_cr, is_lf, is_erase;
    logic [8*SN-1:0]       seq_data;
    logic [SLW-1:0]        seq_len;
    logic                  seq_done;

    // Reset asserts asynchronously and releases on the clock.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign rx_fire   = bus.rx_valid && rx_ready_q;
    assign line_fire = line_valid_q && bus.line_ready;
    assign resp_fire = resp_ready_q && bus.resp_valid;
    assign is_cr     = (bus.rx_data == CR);
    assign is_lf     = (bus.rx_data == LF);
    assign is_erase  = (bus.rx_data == BS) || (bus.rx_data == DEL);

    always_ff @(posedge clk_48mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RX;
            rx_ready_q   <= 1'b0;
            line_valid_q <= 1'b0;
            resp_ready_q <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_ready_q   <= rx_ready_d;
            line_valid_q <= line_valid_d;
            resp_ready_q <= resp_ready_d;
            start_q      <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RX: begin
                if (rx_fire) begin
                    if (is_cr) begin
                        state_d = S_LINE;
                    end else if (ECHO_EN && !is_lf) begin
                        if (is_erase) begin
                            if (count_q != '0) state_d = S_ECHO;
                        end else if (count_q < LINE_MAX) begin
                            state_d = S_ECHO;
                        end
                    end
                end
            end
            S_ECHO, S_TX: if (seq_done) state_d = S_RX;
            S_LINE:       if (line_fire) state_d = S_RESP;
            S_RESP:       if (resp_fire) state_d = S_TX;
            default:      state_d = S_RX;
        endcase
    end

    // Readies are registered from the next state so they track it cycle-exactly.
    always_comb begin
        rx_ready_d   = (state_d == S_RX);
        line_valid_d = (state_d == S_LINE);
        resp_ready_d = (state_d == S_RESP);
        start_d      = (state_d != state_q) && ((state_d == S_ECHO) || (state_d == S_TX));
    end

    always_comb begin
        line_d     = line_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        echo_d     = echo_q;
        echo_len_d = echo_len_q;
        resp_d     = resp_q;
        rlen_d     = rlen_q;
        if (rx_fire && !is_cr && !is_lf) begin
            if (is_erase) begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                    for (int i = 0; i < LINE_LEN; i++) begin
                        if (count_q == CW'(i + 1)) line_d[i] = 8'h00;
                    end
                    echo_d[0]  = BS;
                    echo_d[1]  = SP;
                    echo_d[2]  = BS;
                    echo_len_d = 2'd3;
                end
            end else if (count_q < LINE_MAX) begin
                for (int i = 0; i < LINE_LEN; i++) begin
                    if (count_q == CW'(i)) line_d[i] = bus.rx_data;
                end
                count_d    = count_q + 1'b1;
                echo_d[0]  = bus.rx_data;
                echo_len_d = 2'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (line_fire) begin
            for (int i = 0; i < LINE_LEN; i++) line_d[i] = 8'h00;
            count_d = '0;
            ovf_d   = 1'b0;
        end
        if (resp_fire) begin
            resp_d = bus.resp_data;
            rlen_d = (bus.resp_len > RMAX) ? RMAX : bus.resp_len;
        end
    end

    always_ff @(posedge clk_48mhz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINE_LEN; i++) line_q[i] <= 8'h00;
            for (int i = 0; i < 3; i++) echo_q[i] <= 8'h00;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            echo_len_q <= '0;
            resp_q     <= '0;
            rlen_q     <= '0;
        end else begin
            line_q     <= line_d;
            echo_q     <= echo_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            echo_len_q <= echo_len_d;
            resp_q     <= resp_d;
            rlen_q     <= rlen_d;
        end
    end

    always_comb begin
        seq_data = '0;
        if (state_q == S_ECHO) begin
            seq_data[23:0] = {echo_q[2], echo_q[1], echo_q[0]};
            seq_len        = SLW'(echo_len_q);
        end else begin
            seq_data[8*RESP_LEN-1:0] = resp_q;
            seq_len                  = SLW'(rlen_q);
        end
    end

    console_tx_seq #(
        .N  (SN),
        .LW (SLW)
    ) u_tx_seq (
        .clk        (clk_48mhz),
        .rst_n      (rst_n),
        .start_i    (start_q),
        .data_i     (seq_data),
        .len_i      (seq_len),
        .crlf_i     (state_q == S_TX),
        .tx_valid_o (bus.tx_valid),
        .tx_data_o  (bus.tx_data),
        .tx_ready_i (bus.tx_ready),
        .done_o     (seq_done)
    );

    for (genvar gi = 0; gi < LINE_LEN; gi++) begin : g_line_out
        assign bus.line_data[8*gi +: 8] = line_q[gi];
    end

    assign bus.line_len   = count_q;
    assign bus.line_ovf   = ovf_q;
    assign bus.line_valid = line_valid_q;
    assign bus.rx_ready   = rx_ready_q;
    assign bus.resp_ready = resp_ready_q;
    assign busy           = (state_q != S_RX);

endmodule
